// File: rtl/npc_pkg.sv
// Shared types and defaults for the next-PC sequencer of the P6 pipelined MIPS core.
// Optional feature macro: NPC_EXC_VECTOR_EN (exception vector override, see npc_sequencer).
package npc_pkg;

  localparam int unsigned PC_W        = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
  localparam int unsigned PC_STEP_DEF  = 4;

  // Which redirect source won this cycle's priority selection.
  typedef enum logic [1:0] {
    RK_NONE = 2'd0,
    RK_BR   = 2'd1,
    RK_J    = 2'd2,
    RK_JR   = 2'd3
  } redir_kind_t;

  // Fetch sequencing state: running sequentially, or holding a buffered redirect.
  typedef enum logic {
    ST_SEQ  = 1'b0,
    ST_PEND = 1'b1
  } npc_state_t;

endpackage

// File: rtl/npc_sequencer_jtarget_gen.sv
// Redirect target generator: picks the winning redirect (jr > j > br) from ID and
// computes its 32-bit target. Purely combinational.
// Ports:
//   id_pc      in  32  PC of the instruction in ID
//   br_imm16   in  16  branch offset in words
//   j_imm26    in  26  jump index
//   jr_target  in  32  forwarded rs value
//   br_take / j_take / jr_take  in  1  redirect requests
//   kind_c     out     selected redirect kind (RK_NONE when nothing requested)
//   target_c   out 32  selected target (zero when kind_c == RK_NONE)
module jtarget_gen
  import npc_pkg::*;
(
  input  logic [PC_W-1:0] id_pc,
  input  logic [15:0]     br_imm16,
  input  logic [25:0]     j_imm26,
  input  logic [PC_W-1:0] jr_target,
  input  logic            br_take,
  input  logic            j_take,
  input  logic            jr_take,
  output redir_kind_t     kind_c,
  output logic [PC_W-1:0] target_c
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_off;

  // Delay-slot address is the base for both branch and jump targets.
  assign seq_pc = id_pc + 32'd4;
  assign br_off = {{14{br_imm16[15]}}, br_imm16, 2'b00};

  // Fixed priority select; wrap-around modulo 2^32 is intended.
  always_comb begin
    kind_c   = RK_NONE;
    target_c = '0;
    if (jr_take) begin
      kind_c   = RK_JR;
      target_c = jr_target;
    end else if (j_take) begin
      kind_c   = RK_J;
      target_c = {seq_pc[31:28], j_imm26, 2'b00};
    end else if (br_take) begin
      kind_c   = RK_BR;
      target_c = seq_pc + br_off;
    end
  end

endmodule

// File: rtl/npc_sequencer.sv
// Next-PC sequencer: owns the IF fetch PC, steps it sequentially, applies branch/jump
// redirects from ID, and buffers a redirect that arrives while fetch cannot advance.
// Optional feature macro: NPC_EXC_VECTOR_EN adds exc_req / EXC_PC (exception vector
// override of redirects and stall).
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   stall        hazard freeze of IF/ID
//   if_ready     instruction memory accepts the current fetch
//   exc_req      (NPC_EXC_VECTOR_EN only) force pc to EXC_PC
//   if_valid     fetch request valid (0 only in the cycle after reset)
//   pc           current fetch address
//   id_pc, br_take, br_imm16, j_take, j_imm26, jr_take, jr_target  redirect inputs from ID
//   pending      a redirect is buffered and not yet applied
//   redir_err    sticky: a redirect arrived while one was pending
module npc_sequencer
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PC_STEP  = PC_STEP_DEF
`ifdef NPC_EXC_VECTOR_EN
  ,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            if_ready,
`ifdef NPC_EXC_VECTOR_EN
  input  logic            exc_req,
`endif
  output logic            if_valid,
  output logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] id_pc,
  input  logic            br_take,
  input  logic [15:0]     br_imm16,
  input  logic            j_take,
  input  logic [25:0]     j_imm26,
  input  logic            jr_take,
  input  logic [PC_W-1:0] jr_target,
  output logic            pending,
  output logic            redir_err
);

  npc_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic            redir_err_q, redir_err_d;
  logic            if_valid_q;

  redir_kind_t     kind_c;
  logic [PC_W-1:0] target_c;
  logic            redirect_c;
  logic            advance_c;

  jtarget_gen u_jtarget_gen (
    .id_pc     (id_pc),
    .br_imm16  (br_imm16),
    .j_imm26   (j_imm26),
    .jr_target (jr_target),
    .br_take   (br_take),
    .j_take    (j_take),
    .jr_take   (jr_take),
    .kind_c    (kind_c),
    .target_c  (target_c)
  );

  assign redirect_c = (kind_c != RK_NONE);
  assign advance_c  = if_valid_q & if_ready & ~stall;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SEQ;
      pc_q        <= RESET_PC;
      pend_tgt_q  <= '0;
      redir_err_q <= 1'b0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_tgt_q  <= pend_tgt_d;
      redir_err_q <= redir_err_d;
      if_valid_q  <= 1'b1;
    end
  end

  // Next-state / next-PC selection. The delay-slot fetch is never cancelled: a redirect
  // only replaces the step that would follow the current fetch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_tgt_d  = pend_tgt_q;
    redir_err_d = redir_err_q;

    unique case (state_q)
      ST_SEQ: begin
        if (redirect_c) begin
          if (advance_c) begin
            pc_d = target_c;
          end else begin
            pend_tgt_d = target_c;
            state_d    = ST_PEND;
          end
        end else if (advance_c) begin
          pc_d = pc_q + 32'(PC_STEP);
        end
      end
      ST_PEND: begin
        if (redirect_c) begin
          // Newer redirect replaces the buffered one; flag the overlap.
          redir_err_d = 1'b1;
          if (advance_c) begin
            pc_d    = target_c;
            state_d = ST_SEQ;
          end else begin
            pend_tgt_d = target_c;
          end
        end else if (advance_c) begin
          pc_d    = pend_tgt_q;
          state_d = ST_SEQ;
        end
      end
      default: begin
        state_d = ST_SEQ;
      end
    endcase

`ifdef NPC_EXC_VECTOR_EN
    // Exception vector wins over stall and any redirect; redir_err is left as it was.
    if (exc_req) begin
      pc_d        = EXC_PC;
      state_d     = ST_SEQ;
      redir_err_d = redir_err_q;
    end
`endif
  end

  assign pc        = pc_q;
  assign if_valid  = if_valid_q;
  assign pending   = (state_q == ST_PEND);
  assign redir_err = redir_err_q;

endmodule

// File: doc/npc_sequencer.md
Name: npc_sequencer

Overview:
- Owns the fetch PC register of the P6 pipelined MIPS core.
- Each cycle it selects the next PC from four sources: sequential PC+4, branch target, j/jal jump target, or jr register target.
- Holds the PC during hazard stalls and while instruction memory is not ready.
- Buffers single-cycle redirect pulses from ID until the fetch handshake can consume them.
- Sits between the ID-stage branch/jump decode and the IF-stage instruction memory port.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit freeze of IF/ID
- if_ready  in  1  instruction memory accepts the current fetch
- if_valid  out  1  fetch request valid
- pc  out  32  current fetch address
- id_pc  in  32  PC of the instruction in ID
- br_take  in  1  taken branch in ID (1-cycle pulse)
- br_imm16  in  16  branch offset, in words
- j_take  in  1  j/jal in ID (pulse)
- j_imm26  in  26  jump index
- jr_take  in  1  jr/jalr in ID (pulse)
- jr_target  in  32  forwarded rs value
- pending  out  1  redirect buffered, not yet applied
- redir_err  out  1  sticky; a redirect arrived while one was already pending

Behaviour:
- Reset (synchronous): pc=RESET_PC, if_valid=0, pending=0, redir_err=0, state=SEQ.
- if_valid=1 in every cycle after the first clock edge with reset low.
- advance = if_valid & if_ready & ~stall. The pc register updates only when advance=1; otherwise it holds.
- Target computation (32-bit, wrap-around modulo 2^32, no overflow flag):
  - br: id_pc + 4 + (sext(br_imm16) << 2)
  - j: {(id_pc+4)[31:28], j_imm26, 2'b00}
  - jr: jr_target, used unmodified
- Same-cycle priority among the take inputs: jr > j > br. Lower-priority inputs are ignored.
- Delay slot: a redirect seen while the delay slot (id_pc+4) is being fetched takes effect on the next advance. The delay-slot fetch is never cancelled.
- FSM:
  - SEQ, advance=1, redirect this cycle: pc <- target; stay in SEQ.
  - SEQ, advance=0, redirect this cycle: latch the target into pend_tgt; go to PEND; pending=1.
  - SEQ, no redirect: pc <- pc+PC_STEP on advance.
  - PEND, advance=1: pc <- pend_tgt; go to SEQ; pending=0. A new redirect in that same cycle is treated as a redirect in PEND (below).
  - PEND, new redirect: overwrite pend_tgt with the new target; set redir_err (sticky until reset); stay in PEND unless advance.
  - PEND, new redirect and advance in the same cycle: pc <- new target; go to SEQ.
- Reset during PEND: the buffered target is discarded; pc=RESET_PC.
- stall and if_ready low together: the PC holds; behaves as advance=0.
- The block performs no alignment checks.

Optional Feature:
- Macro: NPC_EXC_VECTOR_EN.
- Defined:
  - Adds input exc_req (1) and parameter EXC_PC (32'h0000_4180).
  - exc_req=1 overrides all redirects and stall: pc <- EXC_PC at the next edge, pending cleared, state=SEQ.
  - redir_err is unaffected.
- Undefined: the exc_req port and the EXC_PC logic are absent; behaviour is exactly as above.

Decomposition:
- Package npc_pkg holds:
  - constants RESET_PC_DEF, EXC_PC_DEF, PC_STEP_DEF
  - enum redir_kind_t {RK_NONE, RK_BR, RK_J, RK_JR}
  - FSM enum npc_state_t {ST_SEQ, ST_PEND}
- Sub-module jtarget_gen: purely combinational.
  - Inputs: id_pc, br_imm16, j_imm26, jr_target, take bits.
  - Outputs: the selected kind and 32-bit target.
- npc_sequencer keeps the FSM, the pc register and pend_tgt.

Test Plan:
- Reset release, if_ready=1, stall=0 -> pc sequence 0x3000, 0x3000, 0x3004, 0x3008; if_valid 0 then 1.
- id_pc=0x3010, br_take pulse, br_imm16=16'hFFFC, advance=1 -> next pc=0x3004 (0x3014-16); no pending.
- id_pc=0x3020, j_take, j_imm26=26'h0000C10, stall=1 for 3 cycles -> pending=1, pc holds; first advance gives pc=0x00003040, pending=0.
- Same cycle jr_take (jr_target=0x3100), j_take, br_take -> pc=0x3100.
- In PEND, a second br_take arrives -> redir_err=1 and stays 1; the later target is applied on advance.
- With NPC_EXC_VECTOR_EN: exc_req during stall in PEND -> pc=0x4180 next edge, pending=0; the pc=0x00010000 case checks wrap: id_pc=0xFFFFFFFC, br_imm16=0 -> target 0x00000000.
